// File: rtl/fetch_decode_pipe.sv
// rtl/fetch_decode_pipe.sv - FETCH_W-lane fetch PC generator with registered predecode stage
// Optional FETCH_PERF_CNT_EN adds saturating perf_groups / perf_redirects counters.
module fetch_decode_pipe #(
    parameter int          FETCH_W   = 4,
    parameter int          PC_W      = 16,
    parameter int          INSTR_W   = 16,
    parameter int          ROB_IDX_W = 4,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         redirect_valid,
    input  logic [PC_W-1:0]              redirect_pc,
    output logic [FETCH_W*PC_W-1:0]      pc_to_icache_flat,
    input  logic                         icache_valid,
    input  logic [FETCH_W*INSTR_W-1:0]   instr_flat,
    input  logic [ROB_IDX_W-1:0]         rob_tail_idx,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]                  perf_groups,
    output logic [31:0]                  perf_redirects,
`endif
    output logic                         dec_valid,
    input  logic                         dec_ready,
    output logic [FETCH_W-1:0]           lane_valid_flat,
    output logic [4*FETCH_W-1:0]         opcode_flat,
    output logic [4*FETCH_W-1:0]         rt_flat,
    output logic [4*FETCH_W-1:0]         ra_flat,
    output logic [4*FETCH_W-1:0]         rb_flat,
    output logic [8*FETCH_W-1:0]         imm_flat,
    output logic [FETCH_W-1:0]           uses_ra_flat,
    output logic [FETCH_W-1:0]           uses_rb_flat,
    output logic [FETCH_W-1:0]           is_ld_st_flat,
    output logic [FETCH_W-1:0]           is_fxu_flat,
    output logic [FETCH_W-1:0]           is_branch_flat,
    output logic [FETCH_W-1:0]           op_a_dep_flat,
    output logic [FETCH_W-1:0]           op_b_dep_flat,
    output logic [ROB_IDX_W*FETCH_W-1:0] op_a_owner_flat,
    output logic [ROB_IDX_W*FETCH_W-1:0] op_b_owner_flat
);

    function automatic logic f_uses_ra(input logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd10, 4'd11};
    endfunction
    function automatic logic f_uses_rb(input logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd4, 4'd10, 4'd11};
    endfunction
    function automatic logic f_writes_rt(input logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6};
    endfunction
    function automatic logic f_ld_st(input logic [3:0] op);
        return op inside {4'd2, 4'd3};
    endfunction
    function automatic logic f_fxu(input logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd4, 4'd5, 4'd6};
    endfunction
    function automatic logic f_branch(input logic [3:0] op);
        return op inside {4'd8, 4'd9, 4'd10, 4'd11};
    endfunction

    logic [PC_W-1:0]            fetch_pc_q, fetch_pc_d;
    logic                       d_valid_q, d_valid_d;
    logic [FETCH_W*INSTR_W-1:0] instr_q, instr_d;
    logic [FETCH_W-1:0]         lane_valid_q, lane_valid_d;

    logic                       f_fire, out_fire;
    logic [FETCH_W-1:0]         keep_mask;
    logic [PC_W-1:0]            pc_step;
    logic                       seen_br;

    logic [3:0] op_l [FETCH_W];
    logic [3:0] rt_l [FETCH_W];
    logic [3:0] ra_l [FETCH_W];
    logic [3:0] rb_l [FETCH_W];
    logic [FETCH_W-1:0] wr_l;

    // Redirect gates the presented group combinationally so a flushed group is never consumed.
    assign dec_valid = d_valid_q & ~redirect_valid;
    assign out_fire  = dec_valid & dec_ready;
    assign f_fire    = icache_valid & (~d_valid_q | dec_ready) & ~redirect_valid;

    always_comb begin
        for (int i = 0; i < FETCH_W; i++) begin
            pc_to_icache_flat[PC_W*i +: PC_W] = fetch_pc_q + PC_W'(2 * i);
        end
    end

    // Keep lanes up to and including the oldest branch; fall-through is assumed.
    always_comb begin
        keep_mask = '0;
        pc_step   = PC_W'(2 * FETCH_W);
        seen_br   = 1'b0;
        for (int i = 0; i < FETCH_W; i++) begin
            if (!seen_br) begin
                keep_mask[i] = 1'b1;
                if (f_branch(instr_flat[INSTR_W*i+12 +: 4])) begin
                    seen_br = 1'b1;
                    pc_step = PC_W'(2 * (i + 1));
                end
            end
        end
    end

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        d_valid_d    = d_valid_q;
        instr_d      = instr_q;
        lane_valid_d = lane_valid_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            d_valid_d  = 1'b0;
        end else if (f_fire) begin
            fetch_pc_d   = fetch_pc_q + pc_step;
            d_valid_d    = 1'b1;
            instr_d      = instr_flat;
            lane_valid_d = keep_mask;
        end else if (out_fire) begin
            d_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q   <= PC_W'(RESET_PC);
            d_valid_q    <= 1'b0;
            instr_q      <= '0;
            lane_valid_q <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            d_valid_q    <= d_valid_d;
            instr_q      <= instr_d;
            lane_valid_q <= lane_valid_d;
        end
    end

    always_comb begin
        wr_l = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            op_l[i] = instr_q[INSTR_W*i+12 +: 4];
            rt_l[i] = instr_q[INSTR_W*i+8 +: 4];
            ra_l[i] = instr_q[INSTR_W*i+4 +: 4];
            rb_l[i] = instr_q[INSTR_W*i +: 4];
            wr_l[i] = lane_valid_q[i] & f_writes_rt(op_l[i]);
            opcode_flat[4*i +: 4] = op_l[i];
            rt_flat[4*i +: 4]     = rt_l[i];
            ra_flat[4*i +: 4]     = ra_l[i];
            rb_flat[4*i +: 4]     = rb_l[i];
            imm_flat[8*i +: 8]    = instr_q[INSTR_W*i+4 +: 8];
            uses_ra_flat[i]       = lane_valid_q[i] & f_uses_ra(op_l[i]);
            uses_rb_flat[i]       = lane_valid_q[i] & f_uses_rb(op_l[i]);
            is_ld_st_flat[i]      = lane_valid_q[i] & f_ld_st(op_l[i]);
            is_fxu_flat[i]        = lane_valid_q[i] & f_fxu(op_l[i]);
            is_branch_flat[i]     = lane_valid_q[i] & f_branch(op_l[i]);
        end
    end

    // Ascending scan so the youngest older producer wins.
    always_comb begin
        op_a_dep_flat = '0;
        op_b_dep_flat = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            op_a_owner_flat[ROB_IDX_W*i +: ROB_IDX_W] = rob_tail_idx + ROB_IDX_W'(i);
            op_b_owner_flat[ROB_IDX_W*i +: ROB_IDX_W] = rob_tail_idx + ROB_IDX_W'(i);
            for (int j = 0; j < i; j++) begin
                if (uses_ra_flat[i] && wr_l[j] && (rt_l[j] == ra_l[i])) begin
                    op_a_dep_flat[i] = 1'b1;
                    op_a_owner_flat[ROB_IDX_W*i +: ROB_IDX_W] = rob_tail_idx + ROB_IDX_W'(j);
                end
                if (uses_rb_flat[i] && wr_l[j] && (rt_l[j] == rb_l[i])) begin
                    op_b_dep_flat[i] = 1'b1;
                    op_b_owner_flat[ROB_IDX_W*i +: ROB_IDX_W] = rob_tail_idx + ROB_IDX_W'(j);
                end
            end
        end
    end

    assign lane_valid_flat = lane_valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_groups_q, perf_redirects_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_groups_q    <= '0;
            perf_redirects_q <= '0;
        end else begin
            if (out_fire && (perf_groups_q != '1)) begin
                perf_groups_q <= perf_groups_q + 32'd1;
            end
            if (redirect_valid && (perf_redirects_q != '1)) begin
                perf_redirects_q <= perf_redirects_q + 32'd1;
            end
        end
    end

    assign perf_groups    = perf_groups_q;
    assign perf_redirects = perf_redirects_q;
`endif

endmodule

// File: doc/fetch_decode_pipe.md
Name: fetch_decode_pipe

Overview:
- Parametrised successor to the 4-wide fetch/predecode stage. Generates FETCH_W sequential PCs to the icache and registers the returned group into a decode stage.
- Predecodes each lane: fields, unit class, and intra-group RAW owner tags.
- Presents the group to the instruction buffer through a valid/ready handshake.
- Adds stall handling, redirect flush, branch-truncated groups, and reset, none of which the previous generation had.

Parameters:
FETCH_W, 4, lanes per group (1..8)
PC_W, 16, PC width; instructions are 2 bytes
INSTR_W, 16, instruction width; opcode [15:12], rt [11:8], ra [7:4], rb [3:0], imm [11:4]
ROB_IDX_W, 4, ROB index width; tags wrap modulo 2^ROB_IDX_W
RESET_PC, 0, PC loaded on reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
redirect_valid  in  1  branch unit redirect/flush
redirect_pc  in  PC_W  redirect target
pc_to_icache_flat  out  FETCH_W*PC_W  lane i = fetch_pc + 2*i
icache_valid  in  1  instr_flat valid this cycle (combinational read)
instr_flat  in  FETCH_W*INSTR_W  lane i at [INSTR_W*i +: INSTR_W]
rob_tail_idx  in  ROB_IDX_W  ROB slot for lane 0 of the presented group
dec_valid  out  1  decoded group available
dec_ready  in  1  instruction buffer accepts the whole group
lane_valid_flat  out  FETCH_W  per-lane valid
opcode_flat / rt_flat / ra_flat / rb_flat  out  4*FETCH_W  fields
imm_flat  out  8*FETCH_W  immediate
uses_ra_flat / uses_rb_flat / is_ld_st_flat / is_fxu_flat / is_branch_flat  out  FETCH_W  class bits
op_a_dep_flat / op_b_dep_flat  out  FETCH_W  source produced by an older lane in the same group
op_a_owner_flat / op_b_owner_flat  out  ROB_IDX_W*FETCH_W  owner ROB tag

All flat buses place lane 0 in the LSBs.

Behaviour:
- Reset, asynchronous:
  - fetch_pc = RESET_PC.
  - d_valid = 0, so dec_valid = 0.
  - All D registers = 0, lane_valid = 0.
- Fire conditions:
  - F fires when icache_valid & (~d_valid | dec_ready) & ~redirect_valid.
  - Output fires when dec_valid & dec_ready.
- On F fire:
  - D captures the group.
  - d_valid <= 1.
  - fetch_pc <= fetch_pc + 2*K, where K = lanes kept. Latency is F to dec_valid = 1 cycle.
- Output fire without F fire: d_valid <= 0.
- Stall (d_valid & ~dec_ready): D and fetch_pc hold; outputs stable.
- icache_valid = 0: fetch_pc holds; no capture.
- Redirect has priority over everything:
  - fetch_pc <= redirect_pc.
  - d_valid <= 0.
  - dec_valid is forced 0 in the same cycle (combinationally gated), so no group is consumed.
- Branch truncation:
  - Lanes after the lowest-index branch lane are invalid; K = branch lane + 1, else K = FETCH_W.
  - Fall-through is assumed; the branch unit redirects if the branch is taken.
- Opcode classes:
  - uses_ra: {0,1,2,3,4,8,9,10,11}
  - uses_rb: {0,1,4,10,11}
  - writes_rt: {0,1,2,4,5,6}
  - ld_st: {2,3}
  - fxu: {0,1,4,5,6}
  - branch: {8,9,10,11}
- Owner tags (combinational from D and rob_tail_idx):
  - Default owner of lane i = rob_tail_idx + i (mod 2^ROB_IDX_W).
  - If lane i uses ra and some valid older lane j<i writes_rt with rt_j == ra_i, take the largest such j: owner = rob_tail_idx + j and op_a_dep = 1.
  - Same rule for rb / op_b.
  - Lane 0 deps are always 0.
  - Invalid lanes have all class/dep bits = 0.
- PC arithmetic wraps modulo 2^PC_W.
- Reset mid-stall clears the group; the buffer sees no dec_valid.

Optional Feature:
- FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_groups (32b) and perf_redirects (32b), reset to 0 and saturating.
  - perf_groups increments on each output fire.
  - perf_redirects increments on each cycle with redirect_valid.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then icache_valid=1 with 4 ALU ops (op 0), dec_ready=1 -> pc_to_icache lane0 = 0,2,4,6; dec_valid at cycle 1; next fetch_pc = 8; owners 5,6,7,8 for rob_tail_idx=5.
- Group [add r1; add r2,r1,r1; ld r3; add r4,r3,r2], rob_tail=14 -> lane1 a/b owner 14 dep=1; lane3 a owner 0 (wrap) dep=1, b owner 15 dep=1.
- Lane1 is opcode 8 -> lane_valid = 0011; next fetch_pc = old+4; lanes 2,3 class bits = 0.
- dec_ready=0 for 3 cycles with icache_valid=1 -> outputs and fetch_pc stable; release -> one fire, then a new group captured the next cycle.
- redirect_valid with redirect_pc=0x40 while dec_valid & dec_ready -> dec_valid=0 that cycle; next cycle fetch_pc lane0 = 0x40, d_valid = 0.
- rst_n asserted mid-stall -> dec_valid drops immediately (async); fetch_pc = RESET_PC; with FETCH_PERF_CNT_EN defined, both counters = 0.
